// File: rtl/c2f_chunk_reader.sv
// Consumer end of the CPU->FPGA chunk ring: owns the chunk RAM, streams each
// committed chunk as 64-bit beats and hands the read pointer back to the host.
module c2f_chunk_reader #(
    parameter int CHUNK_IDX_BITS = 2,
    parameter int CHUNK_OFF_BITS = 4
) (
    input  logic                      pcieClk_in,
    input  logic                      reset_in,
    input  logic                      c2fWriteEnable_in,
    input  logic [7:0]                c2fByteMask_in,
    input  logic [CHUNK_IDX_BITS-1:0] c2fWrPtr_in,
    input  logic [CHUNK_OFF_BITS-1:0] c2fChunkOffset_in,
    input  logic [63:0]               c2fData_in,
    input  logic [CHUNK_IDX_BITS-1:0] c2fCommitPtr_in,
    output logic [CHUNK_IDX_BITS-1:0] c2fRdPtr_out,
    output logic                      c2fDTAck_out,
    output logic [63:0]               oData_out,
    output logic                      oValid_out,
    input  logic                      oReady_in,
    output logic                      oEOP_out
);
    localparam int ADDR_BITS = CHUNK_IDX_BITS + CHUNK_OFF_BITS;
    localparam int DEPTH     = 1 << ADDR_BITS;
    localparam logic [CHUNK_OFF_BITS-1:0] OFF_LAST = '1;
    localparam logic [CHUNK_OFF_BITS-1:0] OFF_ONE  = CHUNK_OFF_BITS'(1);
    localparam logic [CHUNK_IDX_BITS-1:0] IDX_ONE  = CHUNK_IDX_BITS'(1);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    state_t                    state_q;
    logic [CHUNK_IDX_BITS-1:0] rd_ptr_q;
    logic [CHUNK_OFF_BITS-1:0] rd_off_q;
    logic                      issue_done_q;
    logic                      ack_q;

    logic [63:0]               mem [DEPTH];
    logic [63:0]               ram_data_q;
    logic                      ram_vld_q;
    logic                      ram_eop_q;

    logic [63:0]               skid_data_q [2];
    logic [1:0]                skid_eop_q;
    logic                      skid_wr_q;
    logic                      skid_rd_q;
    logic [1:0]                skid_cnt_q;
    logic [1:0]                skid_cnt_d;

    logic                      push;
    logic                      pop;
    logic                      non_empty;
    logic                      room;
    logic                      issue;
    logic [2:0]                in_flight;
    logic [CHUNK_OFF_BITS-1:0] issue_off;
    logic [ADDR_BITS-1:0]      wr_addr;
    logic [ADDR_BITS-1:0]      rd_addr;

    assign oValid_out   = skid_cnt_q != 2'd0;
    assign oData_out    = skid_data_q[skid_rd_q];
    assign oEOP_out     = oValid_out & skid_eop_q[skid_rd_q];
    assign c2fRdPtr_out = rd_ptr_q;
    assign c2fDTAck_out = ack_q;

    // A read is only issued when its data is guaranteed a skid slot one cycle
    // later, counting the beat already in the RAM output register.
    always_comb begin
        push       = ram_vld_q;
        pop        = oValid_out & oReady_in;
        non_empty  = c2fCommitPtr_in != rd_ptr_q;
        in_flight  = {1'b0, skid_cnt_q} + {2'b00, ram_vld_q};
        room       = in_flight <= ({2'b00, pop} + 3'd1);
        issue      = 1'b0;
        issue_off  = rd_off_q;
        case (state_q)
            IDLE: begin
                issue     = non_empty & room;
                issue_off = '0;
            end
            STREAM:  issue = ~issue_done_q & room;
            default: issue = 1'b0;
        endcase
        skid_cnt_d = skid_cnt_q + {1'b0, push} - {1'b0, pop};
        wr_addr    = {c2fWrPtr_in, c2fChunkOffset_in};
        rd_addr    = {rd_ptr_q, issue_off};
    end

    // Chunk RAM: byte-masked writes, registered read, read-during-write = old.
    always_ff @(posedge pcieClk_in) begin
        for (int i = 0; i < 8; i++) begin
            if (c2fWriteEnable_in && c2fByteMask_in[i])
                mem[wr_addr][8*i +: 8] <= c2fData_in[8*i +: 8];
        end
        if (issue)
            ram_data_q <= mem[rd_addr];
    end

    always_ff @(posedge pcieClk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q        <= IDLE;
            rd_ptr_q       <= '0;
            rd_off_q       <= '0;
            issue_done_q   <= 1'b0;
            ack_q          <= 1'b0;
            ram_vld_q      <= 1'b0;
            ram_eop_q      <= 1'b0;
            skid_data_q[0] <= '0;
            skid_data_q[1] <= '0;
            skid_eop_q     <= '0;
            skid_wr_q      <= 1'b0;
            skid_rd_q      <= 1'b0;
            skid_cnt_q     <= '0;
        end else begin
            ack_q     <= 1'b0;
            ram_vld_q <= issue;
            ram_eop_q <= issue_off == OFF_LAST;
            if (issue) begin
                rd_off_q <= issue_off + OFF_ONE;
                if (issue_off == OFF_LAST)
                    issue_done_q <= 1'b1;
            end
            if (push) begin
                skid_data_q[skid_wr_q] <= ram_data_q;
                skid_eop_q[skid_wr_q]  <= ram_eop_q;
                skid_wr_q              <= ~skid_wr_q;
            end
            if (pop)
                skid_rd_q <= ~skid_rd_q;
            skid_cnt_q <= skid_cnt_d;
            case (state_q)
                IDLE: begin
                    if (issue)
                        state_q <= STREAM;
                end
                STREAM: begin
                    // The accepted EOP beat is the last thing in flight.
                    if (pop && oEOP_out) begin
                        state_q      <= IDLE;
                        rd_ptr_q     <= rd_ptr_q + IDX_ONE;
                        rd_off_q     <= '0;
                        issue_done_q <= 1'b0;
                        ack_q        <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_c2f_chunk_reader.sv
// Bench for c2f_chunk_reader: byte-mask vector table, hand-written timing
// sequences and randomized multi-chunk traffic against a RAM/ring model.
`timescale 1ns/1ps
module tb_c2f_chunk_reader;
    logic        clk;
    logic        reset_in;
    logic        c2fWriteEnable_in;
    logic [7:0]  c2fByteMask_in;
    logic [1:0]  c2fWrPtr_in;
    logic [3:0]  c2fChunkOffset_in;
    logic [63:0] c2fData_in;
    logic [1:0]  c2fCommitPtr_in;
    logic [1:0]  c2fRdPtr_out;
    logic        c2fDTAck_out;
    logic [63:0] oData_out;
    logic        oValid_out;
    logic        oReady_in;
    logic        oEOP_out;

    c2f_chunk_reader #(.CHUNK_IDX_BITS(2), .CHUNK_OFF_BITS(4)) dut (
        .pcieClk_in        (clk),
        .reset_in          (reset_in),
        .c2fWriteEnable_in (c2fWriteEnable_in),
        .c2fByteMask_in    (c2fByteMask_in),
        .c2fWrPtr_in       (c2fWrPtr_in),
        .c2fChunkOffset_in (c2fChunkOffset_in),
        .c2fData_in        (c2fData_in),
        .c2fCommitPtr_in   (c2fCommitPtr_in),
        .c2fRdPtr_out      (c2fRdPtr_out),
        .c2fDTAck_out      (c2fDTAck_out),
        .oData_out         (oData_out),
        .oValid_out        (oValid_out),
        .oReady_in         (oReady_in),
        .oEOP_out          (oEOP_out)
    );

    typedef struct {
        logic [63:0] a;
        logic [7:0]  ma;
        logic [63:0] b;
        logic [7:0]  mb;
        logic [63:0] exp;
    } mask_vec_t;

    // ---------------- clock / cycle counter ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [64:0] exp_q[$];
    int          rise_q[$];
    int          eop_q[$];
    int          ack_q[$];
    logic [1:0]  ack_ptr_q[$];
    logic [63:0] ref_mem [64];
    logic [1:0]  cp = 2'd0;
    logic [1:0]  model_rd = 2'd0;
    int          beats = 0;
    int          acks = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          t_commit = 0;
    bit          ready_rand = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_eop = 1'b0;
    logic        prev_ack = 1'b0;
    logic [63:0] prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [64:0] e;
        if (reset_in) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            prev_ack   = 1'b0;
            model_rd   = 2'd0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", oValid_out, 1);
                check("stall_data_held", oData_out, prev_data);
                check("stall_eop_held", oEOP_out, prev_eop);
            end
            if (oValid_out && !prev_valid)
                rise_q.push_back(cyc);
            if (oValid_out && oReady_in) begin
                beats++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: actual %h required no beat (cycle %0d)", oData_out, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", oData_out, e[63:0]);
                    check("beat_eop", oEOP_out, e[64]);
                end
                if (oEOP_out)
                    eop_q.push_back(cyc);
            end
            if (c2fDTAck_out) begin
                acks++;
                ack_q.push_back(cyc);
                ack_ptr_q.push_back(c2fRdPtr_out);
                model_rd = model_rd + 2'd1;
                check("ack_single_cycle", prev_ack, 0);
            end
            check("rd_ptr", c2fRdPtr_out, model_rd);
            prev_valid = oValid_out;
            prev_stall = oValid_out & ~oReady_in;
            prev_data  = oData_out;
            prev_eop   = oEOP_out;
            prev_ack   = c2fDTAck_out;
        end
    end

    // ---------------- ready driver ----------------
    initial begin
        oReady_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            oReady_in = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_word(input logic [1:0] idx, input logic [3:0] off,
                              input logic [63:0] data, input logic [7:0] mask);
        @(posedge clk);
        #1;
        c2fWriteEnable_in = 1'b1;
        c2fWrPtr_in       = idx;
        c2fChunkOffset_in = off;
        c2fData_in        = data;
        c2fByteMask_in    = mask;
        for (int b = 0; b < 8; b++)
            if (mask[b]) ref_mem[{idx, off}][8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic write_end();
        @(posedge clk);
        #1;
        c2fWriteEnable_in = 1'b0;
        c2fByteMask_in    = 8'h00;
    endtask

    task automatic write_chunk_seq(input logic [1:0] idx, input logic [63:0] base);
        for (int o = 0; o < 16; o++)
            write_word(idx, 4'(o), base + 64'(o), 8'hFF);
        write_end();
    endtask

    task automatic push_chunk(input logic [1:0] idx);
        for (int o = 0; o < 16; o++)
            exp_q.push_back({(o == 15), ref_mem[{idx, 4'(o)}]});
    endtask

    task automatic commit(input logic [1:0] ptr);
        @(posedge clk);
        #1;
        c2fCommitPtr_in = ptr;
        cp              = ptr;
        t_commit        = cyc;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(posedge clk);
    endtask

    task automatic clear_timing();
        rise_q.delete();
        eop_q.delete();
        ack_q.delete();
        ack_ptr_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog: actual timeout required test completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main test ----------------
    initial begin
        mask_vec_t vecs[5];
        int t, a0, b0, n;
        logic [1:0] start;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                   8'h0F, 64'hFFFF_FFFF_0000_0000};
        vecs[1] = '{64'h0123_4567_89AB_CDEF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h81, 64'hFF23_4567_89AB_CDFF};
        vecs[2] = '{64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 64'h5555_5555_5555_5555, 8'h00, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[3] = '{64'h0,                   8'hFF, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 64'hDEAD_BEEF_0000_0000};
        vecs[4] = '{64'h0011_2233_4455_6677, 8'hFF, 64'h8899_AABB_CCDD_EEFF, 8'h5A, 64'h0099_22BB_CC55_EE77};

        reset_in          = 1'b0;
        c2fWriteEnable_in = 1'b0;
        c2fByteMask_in    = 8'h00;
        c2fWrPtr_in       = 2'd0;
        c2fChunkOffset_in = 4'd0;
        c2fData_in        = '0;
        c2fCommitPtr_in   = 2'd0;

        // Reset between edges: outputs must clear at once.
        #2 reset_in = 1'b1;
        #1;
        check("reset_valid", oValid_out, 0);
        check("reset_data", oData_out, 0);
        check("reset_eop", oEOP_out, 0);
        check("reset_ack", c2fDTAck_out, 0);
        check("reset_rdptr", c2fRdPtr_out, 0);
        repeat (3) @(posedge clk);
        #2 reset_in = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("empty_no_valid", oValid_out, 0);
        end

        // Basic chunk with exact latency checks.
        clear_timing();
        a0 = acks;
        b0 = beats;
        write_chunk_seq(2'd0, 64'h1000);
        push_chunk(2'd0);
        commit(2'd1);
        t = t_commit;
        wait_drain("basic_drain", 200);
        check("basic_beats", beats - b0, 16);
        check("basic_acks", acks - a0, 1);
        check("basic_rises", rise_q.size(), 1);
        check("basic_first_valid", rise_q.size() > 0 ? rise_q[0] : -1, t + 2);
        check("basic_eop_cycle", eop_q.size() > 0 ? eop_q[0] : -1, t + 17);
        check("basic_ack_cycle", ack_q.size() > 0 ? ack_q[0] : -1, t + 18);
        check("basic_ack_ptr", ack_ptr_q.size() > 0 ? ack_ptr_q[0] : 2'bxx, 2'd1);

        // Wrap and multi-commit: chunks 1,2,3 committed at once.
        clear_timing();
        a0 = acks;
        for (int c = 1; c <= 3; c++)
            write_chunk_seq(2'(c), 64'hC000_0000_0000_0000 + 64'(c * 256));
        for (int c = 1; c <= 3; c++)
            push_chunk(2'(c));
        commit(2'd0);
        wait_drain("wrap_drain", 400);
        check("wrap_acks", acks - a0, 3);
        check("wrap_rises", rise_q.size(), 3);
        check("wrap_eops", eop_q.size(), 3);
        if (ack_ptr_q.size() == 3) begin
            check("wrap_ptr0", ack_ptr_q[0], 2'd2);
            check("wrap_ptr1", ack_ptr_q[1], 2'd3);
            check("wrap_ptr2", ack_ptr_q[2], 2'd0);
        end
        if (rise_q.size() == 3 && eop_q.size() == 3 && ack_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check("wrap_no_bubble", eop_q[k], rise_q[k] + 15);
                check("wrap_ack_cycle", ack_q[k], eop_q[k] + 1);
            end
            for (int k = 0; k < 2; k++)
                check("wrap_gap", rise_q[k + 1], eop_q[k] + 3);
        end

        // Byte-mask vector table, one chunk per vector.
        foreach (vecs[v]) begin
            a0 = acks;
            write_word(cp, 4'd0, vecs[v].a, vecs[v].ma);
            write_word(cp, 4'd0, vecs[v].b, vecs[v].mb);
            for (int o = 1; o < 16; o++)
                write_word(cp, 4'(o), {32'(v), 32'(o)}, 8'hFF);
            write_end();
            exp_q.push_back({1'b0, vecs[v].exp});
            for (int o = 1; o < 16; o++)
                exp_q.push_back({(o == 15), ref_mem[{cp, 4'(o)}]});
            commit(cp + 2'd1);
            wait_drain("mask_drain", 200);
            check("mask_ack", acks - a0, 1);
        end

        // Random backpressure over one chunk.
        a0 = acks;
        b0 = beats;
        write_chunk_seq(cp, 64'h1000);
        push_chunk(cp);
        ready_rand = 1'b1;
        commit(cp + 2'd1);
        wait_drain("bp_drain", 800);
        ready_rand = 1'b0;
        check("bp_beats", beats - b0, 16);
        check("bp_acks", acks - a0, 1);

        // Randomized traffic with staggered commits.
        for (int r = 0; r < 8; r++) begin
            n     = $urandom_range(1, 3);
            start = cp;
            a0    = acks;
            b0    = beats;
            for (int k = 0; k < n; k++) begin
                for (int o = 0; o < 16; o++) begin
                    write_word(start + 2'(k), 4'(o), {$urandom, $urandom}, 8'hFF);
                    write_word(start + 2'(k), 4'(o), {$urandom, $urandom}, 8'($urandom_range(0, 255)));
                end
            end
            write_end();
            for (int k = 0; k < n; k++)
                push_chunk(start + 2'(k));
            ready_rand = ($urandom_range(0, 1) == 1);
            commit(start + 2'd1);
            if (n > 1) begin
                repeat ($urandom_range(0, 12)) @(posedge clk);
                commit(start + 2'(n));
            end
            wait_drain("rand_drain", 1500);
            ready_rand = 1'b0;
            check("rand_beats", beats - b0, 16 * n);
            check("rand_acks", acks - a0, n);
        end

        // Reset mid-chunk: chunk 0 restreams from offset 0.
        @(posedge clk);
        #2 reset_in = 1'b1;
        c2fCommitPtr_in = 2'd0;
        cp = 2'd0;
        @(posedge clk);
        #2 reset_in = 1'b0;
        clear_timing();
        write_chunk_seq(2'd0, 64'h1000);
        push_chunk(2'd0);
        b0 = beats;
        commit(2'd1);
        n = 0;
        while (beats - b0 < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midreset_reached_5", beats - b0, 5);
        @(posedge clk);
        #2 reset_in = 1'b1;
        #1;
        check("midreset_valid", oValid_out, 0);
        check("midreset_data", oData_out, 0);
        check("midreset_eop", oEOP_out, 0);
        check("midreset_ack", c2fDTAck_out, 0);
        check("midreset_rdptr", c2fRdPtr_out, 0);
        exp_q.delete();
        clear_timing();
        push_chunk(2'd0);
        a0 = acks;
        b0 = beats;
        repeat (2) @(posedge clk);
        #2 reset_in = 1'b0;
        wait_drain("midreset_drain", 200);
        check("midreset_beats", beats - b0, 16);
        check("midreset_acks", acks - a0, 1);
        check("midreset_ptr", ack_ptr_q.size() > 0 ? ack_ptr_q[0] : 2'bxx, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
